// File: rtl/tcb_lib_memory.sv
// TCB subordinate RAM: byte-enable writes, full-word reads, fixed DLY-cycle response.
// Misaligned and out-of-range requests are refused and flagged in the response status.
module tcb_lib_memory #(
    parameter int DLY = 1,
    parameter int ADR = 32,
    parameter int DAT = 32,
    parameter int SIZ = 4096,
    localparam int BYT = DAT/8,
    localparam int MAX = $clog2(BYT),
    localparam int SZW = (MAX == 0) ? 1 : $clog2(MAX+1)
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           tcb_vld,
    output logic           tcb_rdy,
    input  logic           tcb_wen,
    input  logic           tcb_ren,
    input  logic           tcb_ndn,
    input  logic [ADR-1:0] tcb_adr,
    input  logic [SZW-1:0] tcb_siz,
    input  logic [BYT-1:0] tcb_ben,
    input  logic [DAT-1:0] tcb_wdt,
    output logic [DAT-1:0] tcb_rdt,
    output logic [1:0]     tcb_sts
);
    localparam int AW   = $clog2(SIZ);
    localparam int IW   = (AW > MAX) ? AW - MAX : 1;
    localparam int WRDS = SIZ / BYT;

    logic [DAT-1:0] mem [WRDS];

    logic           rdy;
    logic           hs;
    logic           err_mis;
    logic           err_rng;
    logic           err;
    logic           wr;
    logic [IW-1:0]  idx;
    logic [DAT-1:0] ben_mask;
    logic [DAT-1:0] rdt_d;
    logic [1:0]     sts_d;

    logic [DLY-1:0]          vld_pipe;
    logic [DLY-1:0][DAT-1:0] rdt_pipe;
    logic [DLY-1:0][1:0]     sts_pipe;

    // Byte-lane ordering belongs to the manager, so endianness is not used here.
    logic unused_ndn;
    assign unused_ndn = tcb_ndn;

    assign tcb_rdy = rdy;
    assign hs      = tcb_vld & rdy;

    generate
        if (AW > MAX) begin : g_idx
            assign idx = tcb_adr[AW-1:MAX];
        end else begin : g_idx_one
            assign idx = '0;
        end
        if (ADR > AW) begin : g_rng
            assign err_rng = |tcb_adr[ADR-1:AW];
        end else begin : g_rng_none
            assign err_rng = 1'b0;
        end
    endgenerate

    always_comb begin
        err_mis = (int'(tcb_siz) > MAX);
        for (int b = 0; b < MAX; b++) begin
            if (tcb_adr[b] && (b < int'(tcb_siz))) err_mis = 1'b1;
        end
        for (int i = 0; i < BYT; i++) begin
            ben_mask[8*i +: 8] = {8{tcb_ben[i]}};
        end
    end

    assign err   = err_mis | err_rng;
    assign wr    = hs & tcb_wen & ~err;
    // Read samples the old word, so a combined read/write returns pre-write data.
    assign rdt_d = (hs & tcb_ren & ~err) ? (mem[idx] & ben_mask) : '0;
    assign sts_d = (hs & (tcb_wen | tcb_ren)) ? {err_rng, err_mis} : 2'b00;

    // rdy is cleared asynchronously, which also blocks writes at a reset edge.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = 0; i < BYT; i++) begin
                if (tcb_ben[i]) mem[idx][8*i +: 8] <= tcb_wdt[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy      <= 1'b0;
            vld_pipe <= '0;
            rdt_pipe <= '0;
            sts_pipe <= '0;
        end else begin
            rdy         <= 1'b1;
            vld_pipe[0] <= hs;
            rdt_pipe[0] <= rdt_d;
            sts_pipe[0] <= sts_d;
            for (int s = 1; s < DLY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                rdt_pipe[s] <= rdt_pipe[s-1];
                sts_pipe[s] <= sts_pipe[s-1];
            end
        end
    end

    assign tcb_rdt = vld_pipe[DLY-1] ? rdt_pipe[DLY-1] : '0;
    assign tcb_sts = vld_pipe[DLY-1] ? sts_pipe[DLY-1] : 2'b00;

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Directed bench for tcb_lib_memory; four instances with DLY=1..4 share one request bus.
module tb_tcb_lib_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        ndn = 1'b0;
    logic [31:0] adr = '0;
    logic [1:0]  siz = '0;
    logic [3:0]  ben = '0;
    logic [31:0] wdt = '0;

    logic        rdy_a [4];
    logic [31:0] rdt_a [4];
    logic [1:0]  sts_a [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tcb_lib_memory #(.DLY(g+1), .ADR(32), .DAT(32), .SIZ(4096)) dut (
            .clk(clk), .rst(rst),
            .tcb_vld(vld), .tcb_rdy(rdy_a[g]),
            .tcb_wen(wen), .tcb_ren(ren), .tcb_ndn(ndn),
            .tcb_adr(adr), .tcb_siz(siz), .tcb_ben(ben), .tcb_wdt(wdt),
            .tcb_rdt(rdt_a[g]), .tcb_sts(sts_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a single cycle; on return the DLY=1 response is visible.
    task automatic xfer(input logic w, input logic r, input logic [31:0] a,
                        input logic [1:0] s, input logic [3:0] b, input logic [31:0] d);
        vld = 1'b1; wen = w; ren = r; adr = a; siz = s; ben = b; wdt = d;
        tick();
        vld = 1'b0; wen = 1'b0; ren = 1'b0;
    endtask

    initial begin
        int cnt;
        // Reset held with a live write request
        vld = 1'b1; wen = 1'b1; adr = 32'h80; siz = 2'd2; ben = 4'hF; wdt = 32'hDEADBEEF;
        tick(); tick();
        chk("rst_rdy", 32'(rdy_a[0]), 32'd0);
        chk("rst_rdt", rdt_a[0], 32'd0);
        chk("rst_sts", 32'(sts_a[0]), 32'd0);
        rst = 1'b1; vld = 1'b0; wen = 1'b0;
        tick();
        chk("rdy_after_rst", 32'(rdy_a[0]), 32'd1);

        // Byte writes then full-word read
        xfer(1, 0, 32'h0, 2'd0, 4'b0001, 32'h00000001);
        xfer(1, 0, 32'h1, 2'd0, 4'b0010, 32'h00002300);
        xfer(1, 0, 32'h2, 2'd0, 4'b0100, 32'h00450000);
        chk("wr8_sts", 32'(sts_a[0]), 32'd0);
        xfer(1, 0, 32'h3, 2'd0, 4'b1000, 32'h67000000);
        xfer(0, 1, 32'h0, 2'd2, 4'hF, 32'h0);
        chk("rd32_rdt", rdt_a[0], 32'h67452301);
        chk("rd32_sts", 32'(sts_a[0]), 32'd0);
        tick();
        chk("rd32_one_cycle", rdt_a[0], 32'd0);

        // Half write; read back with lower lanes disabled
        xfer(1, 0, 32'h10, 2'd2, 4'hF, 32'h0000BEEF);
        xfer(1, 0, 32'h12, 2'd1, 4'b1100, 32'h45670000);
        xfer(0, 1, 32'h10, 2'd2, 4'b1100, 32'h0);
        chk("wr16_upper", rdt_a[0], 32'h45670000);
        xfer(0, 1, 32'h10, 2'd2, 4'hF, 32'h0);
        chk("wr16_full", rdt_a[0], 32'h4567BEEF);

        // Error cases
        xfer(1, 0, 32'h20, 2'd2, 4'hF, 32'hCAFEF00D);
        xfer(1, 0, 32'h21, 2'd2, 4'hF, 32'h11111111);
        chk("mis_wr_sts", 32'(sts_a[0]), 32'd1);
        xfer(0, 1, 32'h20, 2'd2, 4'hF, 32'h0);
        chk("mis_wr_nochg", rdt_a[0], 32'hCAFEF00D);
        xfer(0, 1, 32'h1000, 2'd2, 4'hF, 32'h0);
        chk("rng_sts", 32'(sts_a[0]), 32'd2);
        chk("rng_rdt", rdt_a[0], 32'd0);
        xfer(0, 1, 32'h20, 2'd3, 4'hF, 32'h0);
        chk("siz3_sts", 32'(sts_a[0]), 32'd1);
        chk("siz3_rdt", rdt_a[0], 32'd0);
        xfer(0, 1, 32'h23, 2'd1, 4'b1100, 32'h0);
        chk("mis16_sts", 32'(sts_a[0]), 32'd1);
        xfer(0, 1, 32'h1001, 2'd2, 4'hF, 32'h0);
        chk("both_sts", 32'(sts_a[0]), 32'd3);
        xfer(0, 1, 32'h22, 2'd1, 4'b1100, 32'h0);
        chk("al16_rdt", rdt_a[0], 32'hCAFE0000);
        xfer(0, 0, 32'h1003, 2'd2, 4'hF, 32'h0);
        chk("idle_sts", 32'(sts_a[0]), 32'd0);

        // Simultaneous read/write returns old data
        xfer(1, 0, 32'h30, 2'd2, 4'hF, 32'hAAAAAAAA);
        xfer(1, 1, 32'h30, 2'd2, 4'hF, 32'h55555555);
        chk("rw_old", rdt_a[0], 32'hAAAAAAAA);
        xfer(0, 1, 32'h30, 2'd2, 4'hF, 32'h0);
        chk("rw_new", rdt_a[0], 32'h55555555);

        // Latency sweep: 16 back-to-back reads against every DLY instance
        for (int k = 0; k < 16; k++) xfer(1, 0, 32'h100 + 32'(4*k), 2'd2, 4'hF, 32'hA0000000 + 32'(k));
        tick(); tick(); tick(); tick();
        for (int t = 0; t < 20; t++) begin
            if (t < 16) begin
                vld = 1'b1; wen = 1'b0; ren = 1'b1; adr = 32'h100 + 32'(4*t);
                siz = 2'd2; ben = 4'hF;
            end else begin
                vld = 1'b0; ren = 1'b0;
            end
            tick();
            for (int g = 0; g < 4; g++) begin
                int k;
                k = t - g;
                if (k >= 0 && k < 16) chk($sformatf("lat%0d_t%0d", g+1, t), rdt_a[g], 32'hA0000000 + 32'(k));
                else chk($sformatf("lat%0d_t%0d", g+1, t), rdt_a[g], 32'd0);
            end
        end

        // Reset in mid-flight on the DLY=3 instance
        xfer(1, 0, 32'h40, 2'd2, 4'hF, 32'h12345678);
        tick(); tick(); tick(); tick();
        for (int k = 0; k < 3; k++) xfer(0, 1, 32'h40, 2'd2, 4'hF, 32'h0);
        chk("mid_first_rsp", rdt_a[2], 32'h12345678);
        tick();
        rst = 1'b0;
        vld = 1'b1; wen = 1'b1; adr = 32'h40; siz = 2'd2; ben = 4'hF; wdt = 32'hDEADBEEF;
        #1;
        chk("mid_rst_rdt", rdt_a[2], 32'd0);
        tick(); tick();
        chk("mid_rst_rdy", 32'(rdy_a[2]), 32'd0);
        rst = 1'b1; vld = 1'b0; wen = 1'b0;
        cnt = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            for (int g = 0; g < 4; g++) if (rdt_a[g] != 0 || sts_a[g] != 0) cnt++;
        end
        chk("mid_flushed", 32'(cnt), 32'd0);
        xfer(0, 1, 32'h40, 2'd2, 4'hF, 32'h0);
        chk("rst_no_write", rdt_a[0], 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
